// File: rtl/sp_window_loader.sv
// sp_window_loader: serial pixel stream -> 8x8 window for sp_interpolator.
// Optional macro SP_WIN_SOF_CHECK_EN enables pix_sof restart and sof_err.
module sp_window_loader #(
  parameter int PIX_W = 8,
  parameter int WIN_N = 8,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [PIX_W-1:0]             pix_data,
  input  logic                         pix_valid,
  input  logic                         pix_sof,
  output logic                         pix_ready,
  output logic [WIN_N*WIN_N*PIX_W-1:0] win_flat,
  output logic                         win_valid,
  input  logic                         win_ready,
  output logic [CNT_W-1:0]             win_cnt,
  output logic                         sof_err
);

  localparam int NPIX  = WIN_N * WIN_N;
  localparam int IDX_W = $clog2(NPIX);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NPIX - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sof_err_q, sof_err_d;
  logic             xfer;
  logic             restart;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [PIX_W-1:0] win_q [NPIX];

  assign pix_ready = rst_n & (state_q == FILL);
  assign xfer      = pix_valid & pix_ready;
  assign win_valid = (state_q == HOLD);
  assign win_cnt   = cnt_q;
  assign sof_err   = sof_err_q;

`ifdef SP_WIN_SOF_CHECK_EN
  // sof on a non-first beat restarts the window at index 0
  assign restart = xfer & pix_sof & (idx_q != '0);
`else
  logic unused_sof;
  assign unused_sof = pix_sof;
  assign restart    = 1'b0;
`endif

  // next-state, fill index, handoff counter and write strobe
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    sof_err_d = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = idx_q;
    unique case (1'b1)
      (state_q == FILL): begin
        if (xfer) begin
          wr_en = 1'b1;
          if (restart) begin
            wr_idx    = '0;
            idx_d     = IDX_W'(1);
            sof_err_d = 1'b1;
          end else if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = HOLD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      (state_q == HOLD): begin
        if (win_ready) begin
          state_d = FILL;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = FILL;
    endcase
  end

  // control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      idx_q     <= '0;
      cnt_q     <= '0;
      sof_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      sof_err_q <= sof_err_d;
    end
  end

  // window storage; untouched while holding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPIX; i++) begin
        win_q[i] <= '0;
      end
    end else if (wr_en) begin
      win_q[wr_idx] <= pix_data;
    end
  end

  // raster flatten: Irc at ((r-1)*WIN_N+(c-1))*PIX_W
  always_comb begin
    win_flat = '0;
    for (int i = 0; i < NPIX; i++) begin
      win_flat[i*PIX_W +: PIX_W] = win_q[i];
    end
  end

endmodule

// File: tb/tb_sp_window_loader.sv
// tb_sp_window_loader: random stimulus, queue scoreboard, negedge monitor.
// Reference model is a plain pixel list; build with SP_WIN_SOF_CHECK_EN to match.
module tb_sp_window_loader;

  localparam int NPIX = 64;
  localparam int W    = NPIX * 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   pix_data;
  logic         pix_valid;
  logic         pix_sof;
  logic         pix_ready;
  logic [W-1:0] win_flat;
  logic         win_valid;
  logic         win_ready;
  logic [7:0]   win_cnt;
  logic         sof_err;

  always #5 clk = ~clk;

  sp_window_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_ready (pix_ready),
    .win_flat  (win_flat),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_cnt   (win_cnt),
    .sof_err   (sof_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  byte unsigned px[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_exp;
  bit           m_fill;
  bit           m_hold;
  bit           exp_sof;
  logic [7:0]   exp_cnt;
  bit           sof_en;
  bit           mon_on = 1'b0;
  bit           prev_valid = 1'b0;

  function automatic void chk(string nm, logic [W-1:0] act,
                              logic [W-1:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, expv);
  endfunction

  // monitor: control outputs every cycle, window on each new presentation
  always @(negedge clk) begin
    if (mon_on) begin
      chk("pix_ready", W'(pix_ready), W'(m_fill && rst_n));
      chk("win_valid", W'(win_valid), W'(m_hold));
      chk("win_cnt", W'(win_cnt), W'(exp_cnt));
      chk("sof_err", W'(sof_err), W'(exp_sof));
      if (win_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL window: got unexpected %h expected none", win_flat);
        end else begin
          cur_exp = exp_q.pop_front();
          chk("window", win_flat, cur_exp);
        end
      end else if (win_valid) begin
        chk("hold_stable", win_flat, cur_exp);
      end
      prev_valid = win_valid;
    end
  end

  // one clock of stimulus plus the reference model's view of that edge
  task automatic tick(input bit v, input byte unsigned d,
                      input bit s, input bit r);
    bit acc;
    bit hand;
    logic [W-1:0] f;
    @(negedge clk);
    #1;
    pix_valid = v;
    pix_data  = d;
    pix_sof   = s;
    win_ready = r;
    acc  = v && m_fill;
    hand = m_hold && r;
    @(posedge clk);
    exp_sof = 1'b0;
    if (acc) begin
      if (sof_en && s && px.size() != 0) begin
        px.delete();
        exp_sof = 1'b1;
      end
      px.push_back(d);
      if (px.size() == NPIX) begin
        f = '0;
        for (int k = 0; k < NPIX; k++) f[k*8 +: 8] = px[k];
        exp_q.push_back(f);
        px.delete();
        m_fill = 1'b0;
        m_hold = 1'b1;
      end
    end else if (hand) begin
      m_hold = 1'b0;
      m_fill = 1'b1;
      exp_cnt++;
    end
  endtask

  function automatic byte unsigned dat(int mode, int k);
    if (mode == 0) return 8'd10;
    if (mode == 1) return 8'(k);
    return 8'($urandom);
  endfunction

  // feed beats until the model says a window is complete
  task automatic send_window(input int mode, input bit gap);
    int k;
    int guard;
    bit v;
    k = 0;
    guard = 0;
    while (!m_hold && guard < 2000) begin
      v = gap ? (guard % 2 == 1) : 1'b1;
      tick(v, dat(mode, k), 1'b0, 1'($urandom_range(0, 1)));
      if (v) k++;
      guard++;
    end
    if (!m_hold) begin
      n_chk++;
      $display("FAIL fill_timeout: got %0d beats expected window", k);
    end
  endtask

  // hold with junk input, then hand the window off
  task automatic consume(input int n_wait);
    repeat (n_wait) begin
      tick(1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 1)), 1'b0);
    end
    tick(1'b0, 8'd0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    win_ready = 1'b0;
    px.delete();
    m_fill  = 1'b1;
    m_hold  = 1'b0;
    exp_cnt = '0;
    exp_sof = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_flat", win_flat, '0);
    chk("rst_valid", W'(win_valid), '0);
    chk("rst_cnt", W'(win_cnt), '0);
    chk("rst_sof_err", W'(sof_err), '0);
    rst_n = 1'b1;
  endtask

  initial begin
`ifdef SP_WIN_SOF_CHECK_EN
    sof_en = 1'b1;
`else
    sof_en = 1'b0;
`endif
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = '0;
    win_ready = 1'b0;
    m_fill    = 1'b1;
    m_hold    = 1'b0;
    exp_cnt   = '0;
    exp_sof   = 1'b0;
    mon_on    = 1'b1;
    do_reset();

    // constant 0x0A window
    send_window(0, 1'b0);
    consume(3);

    // ramp, long hold, spot-check I14 and I81
    send_window(1, 1'b0);
    consume(10);
    chk("I14", W'(win_flat[3*8 +: 8]), W'(8'd3));
    chk("I81", W'(win_flat[56*8 +: 8]), W'(8'd56));
    consume(10);

    // every-other-cycle valid
    send_window(1, 1'b1);
    consume(2);

    // partial window discarded by reset
    repeat (30) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
    do_reset();
    send_window(2, 1'b0);
    consume(1);

    // sof mid-window
    repeat (20) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
    tick(1'b1, 8'd99, 1'b1, 1'b0);
    send_window(2, 1'b0);
    consume(1);

    // sof on the first beat is legal
    tick(1'b1, 8'd7, 1'b1, 1'b0);
    send_window(2, 1'b1);
    consume(0);

    // counter wrap
    repeat (256) begin
      send_window(2, 1'b0);
      consume(0);
    end

    repeat (3) tick(1'b0, 8'd0, 1'b0, 1'b0);
    chk("queue_drained", W'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
